// File: rtl/fetch_queue_pkg.sv
// Shared definitions for the IF->ID fetch queue.
// Optional feature: FETCH_QUEUE_BYPASS_EN (see if_id_fetch_queue.sv).
package fetch_queue_pkg;

   localparam int unsigned FQ_DEPTH = 4;
   localparam int unsigned FQ_WIDTH = 32;
   localparam int unsigned FQ_PTR_W = $clog2(FQ_DEPTH);

   // One queued fetch word at the default width.
   typedef struct packed {
      logic [FQ_WIDTH-1:0] pc;
      logic [FQ_WIDTH-1:0] instruction;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_mem.sv
// Fetch queue storage: DEPTH x DW array, synchronous write, asynchronous read.
// The array has no reset; occupancy tracking in the parent masks stale entries.
module fetch_queue_mem
   import fetch_queue_pkg::*;
#(
   parameter int unsigned DEPTH = FQ_DEPTH,
   parameter int unsigned DW    = 2 * FQ_WIDTH
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [DW-1:0]            wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [DW-1:0]            rdata
);

   logic [DW-1:0] mem_q [DEPTH];

   // Write the tail entry on a push.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   // Head entry is read combinationally for first-word-fall-through.
   always_comb begin
      rdata = mem_q[raddr];
   end

endmodule

// File: rtl/if_id_fetch_queue.sv
// IF->ID fetch queue: buffers {pc, instruction} from IF, presents the head
// first-word-fall-through to ID, freezes IF when full, and flushes on a taken
// branch. Optional macro FETCH_QUEUE_BYPASS_EN presents an incoming word the
// same cycle when the queue is empty.
module if_id_fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int unsigned DEPTH = FQ_DEPTH,
   parameter int unsigned WIDTH = FQ_WIDTH
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [WIDTH-1:0]       pcIn,
   input  logic [WIDTH-1:0]       instructionIn,
   input  logic                   branchTaken,
   input  logic                   idStall,
   output logic                   freezeIf,
   output logic                   validOut,
   output logic [WIDTH-1:0]       pcOut,
   output logic [WIDTH-1:0]       instructionOut,
   output logic [$clog2(DEPTH):0] count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef struct packed {
      logic [WIDTH-1:0] pc;
      logic [WIDTH-1:0] instruction;
   } entry_t;

   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic   empty, full;
   logic   push, pop, bypass;
   logic   wr_en, rd_en;
   entry_t in_entry, rd_entry, head;

   fetch_queue_mem #(
      .DEPTH (DEPTH),
      .DW    (2 * WIDTH)
   ) u_mem (
      .clk   (clk),
      .we    (wr_en),
      .waddr (wr_ptr_q),
      .wdata (in_entry),
      .raddr (rd_ptr_q),
      .rdata (rd_entry)
   );

   // Handshake decode: freeze, push/pop qualification, optional bypass, head select.
   always_comb begin
      in_entry.pc          = pcIn;
      in_entry.instruction = instructionIn;

      empty    = (count_q == '0);
      full     = (count_q == CNT_W'(DEPTH));
      freezeIf = full & ~branchTaken;
      push     = ~freezeIf & ~branchTaken & ~rst;
`ifdef FETCH_QUEUE_BYPASS_EN
      bypass   = empty & push;
`else
      bypass   = 1'b0;
`endif
      validOut = ~empty | bypass;
      pop      = validOut & ~idStall & ~branchTaken;

      // A bypassed word that ID accepts never touches storage.
      wr_en    = push & ~(bypass & pop);
      rd_en    = pop & ~bypass;

      if (bypass) begin
         head = in_entry;
      end else if (!empty) begin
         head = rd_entry;
      end else begin
         head = '0;
      end
      pcOut          = head.pc;
      instructionOut = head.instruction;
      count          = count_q;
   end

   // Next pointer/occupancy: flush empties the queue by aligning rd to wr.
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (branchTaken) begin
         rd_ptr_d = wr_ptr_q;
         count_d  = '0;
      end else begin
         if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end
         if (rd_en) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // State registers with synchronous reset overriding push/pop/flush.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: tb/tb_if_id_fetch_queue.sv
// Self-checking bench for if_id_fetch_queue against a queue-based reference
// model; an IF model advances pc by 4 on each accepted push.
module tb_if_id_fetch_queue;

   localparam int DEPTH = 4;
   localparam int WIDTH = 32;
   localparam int CW    = $clog2(DEPTH) + 1;

   typedef struct {
      logic [WIDTH-1:0] pc;
      logic [WIDTH-1:0] ins;
   } ent_t;

   logic             clk = 1'b0;
   logic             rst;
   logic [WIDTH-1:0] pcIn;
   logic [WIDTH-1:0] instructionIn;
   logic             branchTaken;
   logic             idStall;
   logic             freezeIf;
   logic             validOut;
   logic [WIDTH-1:0] pcOut;
   logic [WIDTH-1:0] instructionOut;
   logic [CW-1:0]    count;

   always #5 clk = ~clk;

   if_id_fetch_queue #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .pcIn           (pcIn),
      .instructionIn  (instructionIn),
      .branchTaken    (branchTaken),
      .idStall        (idStall),
      .freezeIf       (freezeIf),
      .validOut       (validOut),
      .pcOut          (pcOut),
      .instructionOut (instructionOut),
      .count          (count)
   );

   ent_t             mq[$];
   int               n_vec = 0;
   int               n_bad = 0;
   logic [WIDTH-1:0] if_pc = 32'd4;

   logic             e_frz, e_val, e_push, e_pop, e_byp;
   logic [WIDTH-1:0] e_pc, e_ins;
   logic [CW-1:0]    e_cnt;

   function automatic logic [WIDTH-1:0] ins_of(input logic [WIDTH-1:0] p);
      return {p[15:0] ^ 16'hC0DE, ~p[15:0]};
   endfunction

   // Apply one cycle of inputs and derive the expected outputs from the model.
   task automatic drive(input logic r, input logic br, input logic st);
      rst           = r;
      branchTaken   = br;
      idStall       = st;
      pcIn          = if_pc;
      instructionIn = ins_of(if_pc);
      #1;
      e_cnt  = CW'(mq.size());
      e_frz  = (mq.size() == DEPTH) && !br;
      e_push = !e_frz && !br && !r;
`ifdef FETCH_QUEUE_BYPASS_EN
      e_byp  = (mq.size() == 0) && e_push;
`else
      e_byp  = 1'b0;
`endif
      e_val  = (mq.size() != 0) || e_byp;
      if (mq.size() != 0) begin
         e_pc  = mq[0].pc;
         e_ins = mq[0].ins;
      end else if (e_byp) begin
         e_pc  = if_pc;
         e_ins = ins_of(if_pc);
      end else begin
         e_pc  = '0;
         e_ins = '0;
      end
      e_pop = e_val && !st && !br;
   endtask

   // Clock edge: advance the model queue and the IF pc model.
   task automatic tick(input logic [WIDTH-1:0] tgt);
      ent_t e;
      @(posedge clk);
      e.pc  = pcIn;
      e.ins = instructionIn;
      if (rst || branchTaken) begin
         mq.delete();
      end else begin
         if (e_pop && mq.size() != 0) mq.delete(0);
         if (e_push && !(e_byp && e_pop)) mq.push_back(e);
      end
      if (rst) if_pc = 32'd4;
      else if (branchTaken) if_pc = tgt;
      else if (e_push) if_pc = if_pc + 32'd4;
      #1;
   endtask

   task automatic do_reset();
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 1'b0, 1'b0);
         tick('0);
      end
   endtask

   task automatic test_reset();
      do_reset();
      drive(1'b1, 1'b0, 1'b0);
      n_vec++; if (count !== '0) begin n_bad++; $display("FAIL reset_count got %0d exp 0", count); end
      n_vec++; if (validOut !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b exp 0", validOut); end
      n_vec++; if (pcOut !== '0) begin n_bad++; $display("FAIL reset_pc got %h exp 0", pcOut); end
      n_vec++; if (instructionOut !== '0) begin n_bad++; $display("FAIL reset_ins got %h exp 0", instructionOut); end
      n_vec++; if (freezeIf !== 1'b0) begin n_bad++; $display("FAIL reset_freeze got %b exp 0", freezeIf); end
      tick('0);
   endtask

   task automatic test_fill();
      for (int k = 0; k < 6; k++) begin
         drive(1'b0, 1'b0, 1'b1);
         n_vec++; if (count !== e_cnt) begin n_bad++; $display("FAIL fill_count k=%0d got %0d exp %0d", k, count, e_cnt); end
         n_vec++; if (count !== CW'((k > 4) ? 4 : k)) begin n_bad++; $display("FAIL fill_count_const k=%0d got %0d", k, count); end
         n_vec++; if (freezeIf !== (k >= 4)) begin n_bad++; $display("FAIL fill_freeze k=%0d got %b exp %b", k, freezeIf, (k >= 4)); end
         n_vec++; if (pcOut !== e_pc) begin n_bad++; $display("FAIL fill_pc k=%0d got %h exp %h", k, pcOut, e_pc); end
         if (k >= 1) begin
            n_vec++; if (pcOut !== 32'd4) begin n_bad++; $display("FAIL fill_pc_held k=%0d got %h exp 4", k, pcOut); end
         end
         tick('0);
      end
   endtask

   task automatic test_drain();
      for (int k = 0; k < 4; k++) begin
         drive(1'b0, 1'b0, 1'b0);
         n_vec++; if (pcOut !== 32'(4 * (k + 1))) begin n_bad++; $display("FAIL drain_pc k=%0d got %h exp %h", k, pcOut, 4 * (k + 1)); end
         n_vec++; if (freezeIf !== (k == 0)) begin n_bad++; $display("FAIL drain_freeze k=%0d got %b exp %b", k, freezeIf, (k == 0)); end
         n_vec++; if (count !== e_cnt) begin n_bad++; $display("FAIL drain_count k=%0d got %0d exp %0d", k, count, e_cnt); end
         tick('0);
      end
   endtask

   task automatic test_flush();
      do_reset();
      for (int k = 0; k < 3; k++) begin
         drive(1'b0, 1'b0, 1'b1);
         tick('0);
      end
      drive(1'b0, 1'b1, 1'b1);
      n_vec++; if (count !== CW'(3)) begin n_bad++; $display("FAIL flush_pre_count got %0d exp 3", count); end
      tick(32'h100);
      drive(1'b0, 1'b0, 1'b1);
      n_vec++; if (count !== '0) begin n_bad++; $display("FAIL flush_count got %0d exp 0", count); end
      n_vec++; if (validOut !== e_val) begin n_bad++; $display("FAIL flush_valid got %b exp %b", validOut, e_val); end
      tick('0);
      drive(1'b0, 1'b0, 1'b1);
      n_vec++; if (pcOut !== 32'h100) begin n_bad++; $display("FAIL flush_target_pc got %h exp 100", pcOut); end
      n_vec++; if (instructionOut !== e_ins) begin n_bad++; $display("FAIL flush_target_ins got %h exp %h", instructionOut, e_ins); end
      tick('0);
   endtask

   task automatic test_flush_full();
      do_reset();
      for (int k = 0; k < 4; k++) begin
         drive(1'b0, 1'b0, 1'b1);
         tick('0);
      end
      drive(1'b0, 1'b1, 1'b1);
      n_vec++; if (freezeIf !== 1'b0) begin n_bad++; $display("FAIL flush_full_freeze got %b exp 0", freezeIf); end
      tick(32'h200);
      drive(1'b0, 1'b0, 1'b1);
      n_vec++; if (count !== '0) begin n_bad++; $display("FAIL flush_full_count got %0d exp 0", count); end
      tick('0);
   endtask

   task automatic test_back_to_back();
      logic [WIDTH-1:0] exp_next;
      logic [CW-1:0]    steady;
      exp_next = 32'd4;
      steady   = '0;
      do_reset();
      for (int k = 0; k < 20; k++) begin
         drive(1'b0, 1'b0, 1'b0);
         if (k == 1) steady = e_cnt;
         n_vec++; if (count !== e_cnt) begin n_bad++; $display("FAIL b2b_count k=%0d got %0d exp %0d", k, count, e_cnt); end
         if (k >= 1) begin
            n_vec++; if (count !== steady) begin n_bad++; $display("FAIL b2b_steady k=%0d got %0d exp %0d", k, count, steady); end
         end
         n_vec++; if (validOut !== e_val) begin n_bad++; $display("FAIL b2b_valid k=%0d got %b exp %b", k, validOut, e_val); end
         if (e_val) begin
            n_vec++; if (pcOut !== exp_next) begin n_bad++; $display("FAIL b2b_seq k=%0d got %h exp %h", k, pcOut, exp_next); end
            exp_next = exp_next + 32'd4;
         end
         tick('0);
      end
   endtask

`ifdef FETCH_QUEUE_BYPASS_EN
   task automatic test_bypass();
      do_reset();
      if_pc = 32'h40;
      drive(1'b0, 1'b0, 1'b0);
      n_vec++; if (validOut !== 1'b1) begin n_bad++; $display("FAIL bypass_valid got %b exp 1", validOut); end
      n_vec++; if (pcOut !== 32'h40) begin n_bad++; $display("FAIL bypass_pc got %h exp 40", pcOut); end
      tick('0);
      drive(1'b0, 1'b0, 1'b1);
      n_vec++; if (count !== '0) begin n_bad++; $display("FAIL bypass_count got %0d exp 0", count); end
      tick('0);
   endtask
`else
   task automatic test_latency();
      do_reset();
      if_pc = 32'h40;
      drive(1'b0, 1'b0, 1'b0);
      n_vec++; if (validOut !== 1'b0) begin n_bad++; $display("FAIL latency_valid0 got %b exp 0", validOut); end
      tick('0);
      drive(1'b0, 1'b0, 1'b1);
      n_vec++; if (validOut !== 1'b1) begin n_bad++; $display("FAIL latency_valid1 got %b exp 1", validOut); end
      n_vec++; if (pcOut !== 32'h40) begin n_bad++; $display("FAIL latency_pc got %h exp 40", pcOut); end
      tick('0);
   endtask
`endif

   task automatic test_random();
      logic             r, br, st;
      logic [WIDTH-1:0] tgt;
      do_reset();
      for (int k = 0; k < 400; k++) begin
         r   = ($urandom_range(63) == 0);
         br  = ($urandom_range(7) == 0);
         st  = ($urandom_range(2) == 0);
         tgt = $urandom & 32'h0000_FFFC;
         drive(r, br, st);
         n_vec++; if (count !== e_cnt) begin n_bad++; $display("FAIL rnd_count k=%0d got %0d exp %0d", k, count, e_cnt); end
         n_vec++; if (freezeIf !== e_frz) begin n_bad++; $display("FAIL rnd_freeze k=%0d got %b exp %b", k, freezeIf, e_frz); end
         n_vec++; if (validOut !== e_val) begin n_bad++; $display("FAIL rnd_valid k=%0d got %b exp %b", k, validOut, e_val); end
         n_vec++; if (pcOut !== e_pc) begin n_bad++; $display("FAIL rnd_pc k=%0d got %h exp %h", k, pcOut, e_pc); end
         n_vec++; if (instructionOut !== e_ins) begin n_bad++; $display("FAIL rnd_ins k=%0d got %h exp %h", k, instructionOut, e_ins); end
         tick(tgt);
      end
   endtask

   initial begin
      rst           = 1'b1;
      branchTaken   = 1'b0;
      idStall       = 1'b0;
      pcIn          = '0;
      instructionIn = '0;
      test_reset();
      test_fill();
      test_drain();
      test_flush();
      test_flush_full();
      test_back_to_back();
`ifdef FETCH_QUEUE_BYPASS_EN
      test_bypass();
`else
      test_latency();
`endif
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
